wb_sram_arbiter: RTL and testbench

//   Two-master, one-slave Wishbone arbiter that shares the on-chip wbsram between

---
 rtl/wb_sram_arbiter.sv | 160 ++++++++++++++++
 tb/tb_wb_sram_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_sram_arbiter.sv
// wb_sram_arbiter
//   Shares one Wishbone slave (the on-chip wbsram) between two masters:
//   master 0 (CPU) and master 1 (DMA / frame fetch). Ownership is decided
//   round-robin and is held for the whole bus cycle (cyc), so bursts from
//   the two masters are never interleaved. A per-access watchdog returns
//   err to the owning master if the slave stalls for TIMEOUT cycles.
//
// Ports
//   wb_clk_i, wb_reset_i           clock, asynchronous active-high reset
//   mN_adr_i/dat_i/we_i/sel_i      master N request (N = 0,1)
//   mN_cyc_i/stb_i                 master N bus cycle / strobe
//   mN_dat_o/ack_o/err_o           master N read data, acknowledge, timeout error
//   s_adr_o/dat_o/we_o/sel_o       request forwarded to the slave
//   s_cyc_o/stb_o                  cycle / strobe forwarded to the slave
//   s_dat_i/ack_i                  slave read data / acknowledge
//   grant_o                        one-hot current owner, 0 when idle
//
// state | meaning
// IDLE  | no owner, slave outputs held at 0
// BUS0  | master 0 owns the slave until it drops cyc
// BUS1  | master 1 owns the slave until it drops cyc
module wb_sram_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              wb_clk_i,
    input  logic              wb_reset_i,
    input  logic [AW-1:0]     m0_adr_i,
    input  logic [DW-1:0]     m0_dat_i,
    output logic [DW-1:0]     m0_dat_o,
    input  logic              m0_we_i,
    input  logic [DW/8-1:0]   m0_sel_i,
    input  logic              m0_cyc_i,
    input  logic              m0_stb_i,
    output logic              m0_ack_o,
    output logic              m0_err_o,
    input  logic [AW-1:0]     m1_adr_i,
    input  logic [DW-1:0]     m1_dat_i,
    output logic [DW-1:0]     m1_dat_o,
    input  logic              m1_we_i,
    input  logic [DW/8-1:0]   m1_sel_i,
    input  logic              m1_cyc_i,
    input  logic              m1_stb_i,
    output logic              m1_ack_o,
    output logic              m1_err_o,
    output logic [AW-1:0]     s_adr_o,
    output logic [DW-1:0]     s_dat_o,
    output logic              s_we_o,
    output logic [DW/8-1:0]   s_sel_o,
    output logic              s_cyc_o,
    output logic              s_stb_o,
    input  logic [DW-1:0]     s_dat_i,
    input  logic              s_ack_i,
    output logic [1:0]        grant_o
);

    // A zero TIMEOUT still needs a one-bit timer to keep the declaration legal.
    localparam int            TW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS0 = 2'd1,
        BUS1 = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic          r_last;
    logic [TW-1:0] r_timer;
    logic          w_own_stb;
    logic          w_err_cond;

    always_ff @(posedge wb_clk_i or posedge wb_reset_i) begin
        if (wb_reset_i) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            if (w_next != r_state) begin
                if (w_next == BUS0) r_last <= 1'b0;
                if (w_next == BUS1) r_last <= 1'b1;
            end
            // err_cond forces s_stb_o low, so an error also restarts the timer.
            if ((w_next != r_state) || s_ack_i || !s_stb_o) begin
                r_timer <= '0;
            end else if (r_timer != TMAX) begin
                r_timer <= r_timer + TW'(1);
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) w_next = r_last ? BUS0 : BUS1;
                else if (m0_cyc_i)        w_next = BUS0;
                else if (m1_cyc_i)        w_next = BUS1;
            end
            // Hand over straight to the other master when it is waiting.
            BUS0: if (!m0_cyc_i) w_next = m1_cyc_i ? BUS1 : IDLE;
            BUS1: if (!m1_cyc_i) w_next = m0_cyc_i ? BUS0 : IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_own_stb = 1'b0;
        if (r_state == BUS0) w_own_stb = m0_stb_i;
        if (r_state == BUS1) w_own_stb = m1_stb_i;
        w_err_cond = (TIMEOUT != 0) && (r_timer == TMAX) && w_own_stb && !s_ack_i;
    end

    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_dat_o = '0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_dat_o = '0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        grant_o  = 2'b00;
        case (r_state)
            BUS0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i & ~w_err_cond;
                m0_dat_o = s_dat_i;
                m0_ack_o = s_ack_i & m0_cyc_i;
                m0_err_o = w_err_cond & m0_cyc_i;
                grant_o  = 2'b01;
            end
            BUS1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i & ~w_err_cond;
                m1_dat_o = s_dat_i;
                m1_ack_o = s_ack_i & m1_cyc_i;
                m1_err_o = w_err_cond & m1_cyc_i;
                grant_o  = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_wb_sram_arbiter.sv
// tb_wb_sram_arbiter
//   Drives two Wishbone masters into wb_sram_arbiter (TIMEOUT=4) backed by a
//   small registered-ack SRAM model, plus a second instance with the watchdog
//   disabled (TIMEOUT=0) whose slave never acknowledges.
module tb_wb_sram_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       m_cyc, m_stb, m_we;
    logic [1:0][31:0] m_adr, m_dat;
    logic [1:0][3:0]  m_sel;
    wire  [1:0][31:0] m_dato;
    wire  [1:0]       m_ack, m_err;
    wire  [31:0]      s_adr, s_wdat;
    wire              s_we, s_cyc, s_stb;
    wire  [3:0]       s_sel;
    wire  [1:0]       grant;
    logic             s_ack;
    logic [31:0]      s_rdat;
    logic             noack;

    wire  [1:0][31:0] nt_dato;
    wire  [1:0]       nt_ack, nt_err;
    wire  [31:0]      nt_adr, nt_sdat;
    wire              nt_we, nt_cyc, nt_stb;
    wire  [3:0]       nt_sel;
    wire  [1:0]       nt_grant;

    int n_chk = 0;
    int n_err = 0;

    wb_sram_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .wb_clk_i(clk), .wb_reset_i(rst),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(m_dato[0]), .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(m_ack[0]),
        .m0_err_o(m_err[0]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(m_dato[1]), .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(m_ack[1]),
        .m1_err_o(m_err[1]),
        .s_adr_o(s_adr), .s_dat_o(s_wdat), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_dat_i(s_rdat), .s_ack_i(s_ack),
        .grant_o(grant)
    );

    wb_sram_arbiter #(.AW(32), .DW(32), .TIMEOUT(0)) dut_nt (
        .wb_clk_i(clk), .wb_reset_i(rst),
        .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_dat_o(nt_dato[0]), .m0_we_i(m_we[0]),
        .m0_sel_i(m_sel[0]), .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_ack_o(nt_ack[0]),
        .m0_err_o(nt_err[0]),
        .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_dat_o(nt_dato[1]), .m1_we_i(m_we[1]),
        .m1_sel_i(m_sel[1]), .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_ack_o(nt_ack[1]),
        .m1_err_o(nt_err[1]),
        .s_adr_o(nt_adr), .s_dat_o(nt_sdat), .s_we_o(nt_we), .s_sel_o(nt_sel),
        .s_cyc_o(nt_cyc), .s_stb_o(nt_stb), .s_dat_i(s_rdat), .s_ack_i(1'b0),
        .grant_o(nt_grant)
    );

    // SRAM slave: one access per strobe, registered ack and read data.
    logic [31:0] sram [0:15];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            s_ack  <= 1'b0;
            s_rdat <= '0;
        end else begin
            s_ack <= 1'b0;
            if (s_cyc && s_stb && !s_ack && !noack) begin
                s_ack  <= 1'b1;
                s_rdat <= sram[s_adr[3:0]];
                if (s_we)
                    for (int b = 0; b < 4; b++)
                        if (s_sel[b]) sram[s_adr[3:0]][8*b +: 8] <= s_wdat[8*b +: 8];
            end
        end
    end

    // Reference model: expected memory contents and the last granted master.
    logic [31:0] exp_mem [0:15];
    int          exp_last;
    logic [31:0] rd_last;

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int m, input bit cyc, input bit stb, input bit we,
                         input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        m_cyc[m] = cyc;
        m_stb[m] = stb;
        m_we[m]  = we;
        m_adr[m] = a;
        m_dat[m] = d;
        m_sel[m] = s;
    endtask

    task automatic drop(input int m);
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    // Waits for master m's ack; the other master must see no ack meanwhile.
    task automatic wait_ack(input int m, input int n0, output int n);
        bit got;
        got = 1'b0;
        n = n0;
        while (!got && n < 12) begin
            @(posedge clk); #1;
            n++;
            chk("other_ack_zero", m_ack[1-m], 1'b0);
            if (m_ack[m]) got = 1'b1;
            else chk("no_err_while_wait", m_err[m], 1'b0);
        end
        chk("ack_seen", got, 1'b1);
    endtask

    task automatic finish_beat(input int m, input bit we, input logic [3:0] a,
                               input logic [31:0] d, input logic [3:0] s);
        if (we) begin
            exp_mem[a] = merge(exp_mem[a], d, s);
        end else begin
            chk("rd_data", m_dato[m], exp_mem[a]);
            rd_last = m_dato[m];
        end
        chk("nonowner_dat_zero", m_dato[1-m], 32'h0);
        chk("nonowner_err_zero", m_err[1-m], 1'b0);
    endtask

    // One arbitration round from idle: requesting masters raise cyc+stb on the
    // same edge, each performs a single beat and then drops cyc.
    task automatic run_round(input bit r0, input bit r1, input bit w0, input bit w1,
                             input logic [3:0] a0, input logic [3:0] a1,
                             input logic [31:0] d0, input logic [31:0] d1,
                             input logic [3:0] s0, input logic [3:0] s1);
        int win, oth, n;
        bit oth_req;
        logic [1:0] wv;
        logic [1:0][3:0] av, sv;
        logic [1:0][31:0] dv;
        wv = {w1, w0};
        av = {a1, a0};
        sv = {s1, s0};
        dv = {d1, d0};
        if (r0 && r1) win = (exp_last == 1) ? 0 : 1;
        else          win = r0 ? 0 : 1;
        oth = 1 - win;
        oth_req = (oth == 0) ? r0 : r1;
        if (r0) drive(0, 1'b1, 1'b1, w0, 32'(a0), d0, s0);
        if (r1) drive(1, 1'b1, 1'b1, w1, 32'(a1), d1, s1);
        chk("grant_before_edge", grant, 2'b00);
        @(posedge clk); #1;
        chk("grant_winner", grant, 64'(1) << win);
        exp_last = win;
        wait_ack(win, 1, n);
        chk("latency_winner", n, 2);
        finish_beat(win, wv[win], av[win], dv[win], sv[win]);
        drop(win);
        if (oth_req) begin
            @(posedge clk); #1;
            chk("grant_handover", grant, 64'(1) << oth);
            exp_last = oth;
            wait_ack(oth, 1, n);
            chk("latency_other", n, 2);
            finish_beat(oth, wv[oth], av[oth], dv[oth], sv[oth]);
            drop(oth);
        end
        @(posedge clk); #1;
        chk("grant_idle", grant, 2'b00);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        bit got;
        int r;
        logic [31:0] d;

        m_cyc = '0; m_stb = '0; m_we = '0; m_adr = '0; m_dat = '0; m_sel = '0;
        noack = 1'b0;
        exp_last = 1;
        rd_last = '0;
        #1 rst = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b1, 32'd5, 32'hCAFEF00D, 4'hF);
        drive(1, 1'b1, 1'b1, 1'b0, 32'd6, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_s_cyc", s_cyc, 1'b0);
        chk("rst_s_stb", s_stb, 1'b0);
        chk("rst_s_adr", s_adr, 32'h0);
        chk("rst_s_dat", s_wdat, 32'h0);
        chk("rst_s_we_sel", {s_we, s_sel}, 5'h0);
        chk("rst_acks", m_ack, 2'b00);
        chk("rst_errs", m_err, 2'b00);
        chk("rst_dat0", m_dato[0], 32'h0);
        drop(0); drop(1);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Simultaneous requests after reset: m0 first, direct handover, m0 again.
        run_round(1'b1, 1'b1, 1'b1, 1'b1, 4'd12, 4'd13, $urandom, $urandom, 4'hF, 4'hF);
        run_round(1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 4'd15, $urandom, $urandom, 4'hF, 4'hF);

        for (int a = 0; a < 16; a++) begin
            d = $urandom;
            run_round(1'b1, 1'b0, 1'b1, 1'b0, 4'(a), 4'd0, d, 32'h0, 4'hF, 4'h0);
        end

        run_round(1'b1, 1'b0, 1'b1, 1'b0, 4'd5, 4'd0, 32'hDEADBEEF, 32'h0, 4'hF, 4'h0);
        run_round(1'b1, 1'b0, 1'b0, 1'b0, 4'd5, 4'd0, 32'h0, 32'h0, 4'hF, 4'h0);
        chk("t1_readback", rd_last, 32'hDEADBEEF);

        run_round(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 32'h0, 32'h11223344, 4'h0, 4'hF);
        run_round(1'b0, 1'b1, 1'b0, 1'b1, 4'd0, 4'd7, 32'h0, 32'h0000AB00, 4'h0, 4'b0010);
        run_round(1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd7, 32'h0, 32'h0, 4'h0, 4'hF);
        chk("t4_byte_merge", rd_last, 32'h1122AB44);

        // m0 holds a 4-beat burst while m1 waits.
        drive(0, 1'b1, 1'b1, 1'b0, 32'd0, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("t3_grant_m0", grant, 2'b01);
        drive(1, 1'b1, 1'b1, 1'b0, 32'd9, 32'h0, 4'hF);
        for (int beat = 0; beat < 4; beat++) begin
            got = 1'b0;
            n = 0;
            while (!got && n < 12) begin
                @(posedge clk); #1;
                n++;
                chk("t3_s_adr_not_m1", s_adr != m_adr[1], 1'b1);
                chk("t3_m1_no_ack", m_ack[1], 1'b0);
                chk("t3_grant_held", grant, 2'b01);
                if (m_ack[0]) got = 1'b1;
            end
            chk("t3_beat_ack", got, 1'b1);
            chk("t3_beat_data", m_dato[0], exp_mem[beat]);
            if (beat < 3) m_adr[0] = 32'(beat + 1);
        end
        drop(0);
        @(posedge clk); #1;
        chk("t3_grant_m1", grant, 2'b10);
        wait_ack(1, 1, n);
        chk("t3_m1_latency", n, 2);
        finish_beat(1, 1'b0, 4'd9, 32'h0, 4'hF);
        drop(1);
        exp_last = 1;
        @(posedge clk); #1;
        chk("t3_idle", grant, 2'b00);

        for (int i = 0; i < 16; i++) begin
            r = $urandom_range(1, 3);
            run_round(r[0], r[1], 1'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                      $urandom, $urandom, 4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)));
        end

        // Watchdog: stalled slave, err on the 5th stalled cycle with TIMEOUT=4.
        noack = 1'b1;
        drive(0, 1'b1, 1'b1, 1'b0, 32'd1, 32'h0, 4'hF);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (k == 5) begin
                chk("t5_err_pulse", m_err[0], 1'b1);
                chk("t5_stb_masked", s_stb, 1'b0);
                chk("t5_no_ack_with_err", m_ack[0], 1'b0);
            end else begin
                chk("t5_no_err", m_err[0], 1'b0);
                chk("t5_stb_high", s_stb, 1'b1);
            end
            chk("t5_m1_err_zero", m_err[1], 1'b0);
            chk("t5_nt_no_err", nt_err[0], 1'b0);
        end
        for (int k = 0; k < 24; k++) begin
            @(posedge clk); #1;
            chk("t5_nt_no_err_long", nt_err[0], 1'b0);
            chk("t5_nt_stb_high", nt_stb, 1'b1);
        end
        chk("t5_nt_grant", nt_grant, 2'b01);
        chk("t5_nt_cyc", nt_cyc, 1'b1);
        chk("t5_nt_adr", nt_adr, m_adr[0]);
        chk("t5_nt_wdat", nt_sdat, m_dat[0]);
        chk("t5_nt_we_sel", {nt_we, nt_sel}, 5'b0_1111);
        chk("t5_nt_dat0", nt_dato[0], s_rdat);
        chk("t5_nt_dat1", nt_dato[1], 32'h0);
        chk("t5_nt_acks", nt_ack, 2'b00);
        chk("t5_nt_err1", nt_err[1], 1'b0);
        drop(0);
        noack = 1'b0;
        exp_last = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("t5_idle", grant, 2'b00);

        // Reset in the middle of an m1 burst.
        drive(1, 1'b1, 1'b1, 1'b0, 32'd7, 32'h0, 4'hF);
        @(posedge clk); #1;
        chk("t6_grant_m1", grant, 2'b10);
        wait_ack(1, 1, n);
        finish_beat(1, 1'b0, 4'd7, 32'h0, 4'hF);
        m_adr[1] = 32'd8;
        #3 rst = 1'b1;
        #1;
        chk("t6_s_cyc", s_cyc, 1'b0);
        chk("t6_s_stb", s_stb, 1'b0);
        chk("t6_grant", grant, 2'b00);
        chk("t6_acks", m_ack, 2'b00);
        chk("t6_errs", m_err, 2'b00);
        chk("t6_dat1", m_dato[1], 32'h0);
        @(posedge clk); #1;
        chk("t6_grant_held_rst", grant, 2'b00);
        @(posedge clk); #1;
        drop(1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        exp_last = 1;
        run_round(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 4'd3, 32'h0, 32'h0, 4'hF, 4'hF);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
